pdm_cic_decimator: RTL

Downstream stage of the microphone clock generator. It samples the PDM bit stream from the microphone on the selected edge of the generated mic clock and decimates it with a 3-stage CIC filter (differential delay 1). It delivers signed PCM samples on a valid/ready interface to the audio buffer. The block is fully synchronous to clk_board; mic_clk is a registered clk_board-domain signal and is edge-detected, never used as a clock.

---
 rtl/pdm_cic_decimator_if.sv | 12 +
 rtl/pdm_cic_decimator.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator_if.sv
// PCM sample handshake between the CIC decimator and the audio buffer.
// Valid/ready: a sample transfers on any cycle where both are high.
interface pdm_cic_decimator_if #(
    parameter int OUT_W = 16
);
    logic signed [OUT_W-1:0] pcm_data;
    logic                    pcm_valid;
    logic                    pcm_ready;

    modport master (output pcm_data, output pcm_valid, input pcm_ready);
    modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: samples the bit stream on a mic_clk edge and
// decimates it with a 3-stage CIC (M=1) into signed PCM on a valid/ready port.
module pdm_cic_decimator #(
    parameter int DEC_FACTOR  = 64,
    parameter int OUT_W       = 16,
    parameter int SAMPLE_EDGE = 0
) (
    input  logic                clk_board,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mic_clk,
    input  logic                pdm_data,
    output logic                overrun,
    input  logic                overrun_clr,
    pdm_cic_decimator_if.master pcm
);
    localparam int CNT_W = $clog2(DEC_FACTOR);
    localparam int ACC_W = 3 * CNT_W + 2;

    logic en_meta, en_sync, pdm_meta, pdm_sync, mic_clk_d1;
    logic sample_stb, frame_end, dec_stb, warm_done, load;
    logic [CNT_W-1:0] frame_cnt;
    logic [1:0] warm_cnt;
    logic signed [ACC_W-1:0] x, i1, i2, i3, i1_nxt, i2_nxt, i3_nxt;
    logic signed [ACC_W-1:0] d1, d2, d3, c1, c2, c3;
    logic signed [OUT_W-1:0] pcm_data_r;
    logic pcm_valid_r;

    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            en_meta    <= 1'b0;
            en_sync    <= 1'b0;
            pdm_meta   <= 1'b0;
            pdm_sync   <= 1'b0;
            mic_clk_d1 <= 1'b0;
        end else begin
            en_meta    <= en;
            en_sync    <= en_meta;
            pdm_meta   <= pdm_data;
            pdm_sync   <= pdm_meta;
            mic_clk_d1 <= mic_clk;
        end
    end

    // mic_clk is data here; its edge becomes a one-cycle sample strobe
    assign sample_stb = en_sync & ((SAMPLE_EDGE == 0) ? (mic_clk & ~mic_clk_d1)
                                                      : (~mic_clk & mic_clk_d1));
    assign frame_end  = (frame_cnt == CNT_W'(DEC_FACTOR - 1));
    assign x          = pdm_sync ? ACC_W'(1) : '1;
    assign i1_nxt     = i1 + x;
    assign i2_nxt     = i2 + i1_nxt;
    assign i3_nxt     = i3 + i2_nxt;

    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            frame_cnt <= '0;
            dec_stb   <= 1'b0;
        end else if (!en_sync) begin
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            frame_cnt <= '0;
            dec_stb   <= 1'b0;
        end else begin
            dec_stb <= sample_stb & frame_end;
            if (sample_stb) begin
                i1        <= i1_nxt;
                i2        <= i2_nxt;
                i3        <= i3_nxt;
                frame_cnt <= frame_end ? '0 : frame_cnt + CNT_W'(1);
            end
        end
    end

    assign c1        = i3 - d1;
    assign c2        = c1 - d2;
    assign c3        = c2 - d3;
    assign warm_done = (warm_cnt == 2'd2);
    // first two comb results still carry the integrator start-up transient
    assign load      = en_sync & dec_stb & warm_done;

    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            d1          <= '0;
            d2          <= '0;
            d3          <= '0;
            warm_cnt    <= 2'd0;
            pcm_data_r  <= '0;
            pcm_valid_r <= 1'b0;
        end else if (!en_sync) begin
            d1          <= '0;
            d2          <= '0;
            d3          <= '0;
            warm_cnt    <= 2'd0;
            pcm_data_r  <= '0;
            pcm_valid_r <= 1'b0;
        end else begin
            if (dec_stb) begin
                d1 <= i3;
                d2 <= c1;
                d3 <= c2;
                if (!warm_done) warm_cnt <= warm_cnt + 2'd1;
            end
            if (load) begin
                pcm_data_r  <= OUT_W'(c3 >>> (ACC_W - OUT_W));
                pcm_valid_r <= 1'b1;
            end else if (pcm_valid_r && pcm.pcm_ready) begin
                pcm_valid_r <= 1'b0;
            end
        end
    end

    // overrun survives en going low; a same-cycle set beats the clear
    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n)                                   overrun <= 1'b0;
        else if (load && pcm_valid_r && !pcm.pcm_ready) overrun <= 1'b1;
        else if (overrun_clr)                         overrun <= 1'b0;
    end

    assign pcm.pcm_data  = pcm_data_r;
    assign pcm.pcm_valid = pcm_valid_r;
endmodule
